// File: rtl/cond_update_sched.sv
// Round-robin scheduler sharing one condition register between requesters.
// Each grant computes period * freq_adj serially and commits it only on a counter wrap.
module cond_update_sched #(
  parameter int NREQ = 2,
  parameter int W    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_period,
  input  logic [NREQ*W-1:0] req_freq_adj,
  output logic [NREQ-1:0]   gnt,
  input  logic              wrap,
  output logic [31:0]       condition,
  output logic              cond_upd,
  output logic              op_err,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_WAIT,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [31:0]     r_opa, w_opa_next;
  logic [W-1:0]    r_opb, w_opb_next;
  logic [31:0]     r_acc, w_acc_next;
  logic [CW-1:0]   r_bit, w_bit_next;
  logic [31:0]     r_condition, w_condition_next;
  logic [NREQ-1:0] r_gnt, w_gnt_next;
  logic            r_cond_upd, w_cond_upd_next;
  logic            r_op_err, w_op_err_next;
  logic            r_busy, w_busy_next;

  logic [W-1:0]    w_period [NREQ];
  logic [W-1:0]    w_freq   [NREQ];
  logic [PW-1:0]   w_pick;
  logic [W-1:0]    w_sel_period;
  logic [W-1:0]    w_sel_freq;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_period[gi] = req_period[gi*W +: W];
      assign w_freq[gi]   = req_freq_adj[gi*W +: W];
    end
  endgenerate

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    int idx;
    w_pick = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) w_pick = idx[PW-1:0];
    end
  end

  assign w_sel_period = w_period[w_pick];
  assign w_sel_freq   = w_freq[w_pick];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_opa_next       = r_opa;
    w_opb_next       = r_opb;
    w_acc_next       = r_acc;
    w_bit_next       = r_bit;
    w_condition_next = r_condition;
    w_gnt_next       = '0;
    w_cond_upd_next  = 1'b0;
    w_op_err_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_next    = NREQ'(1) << w_pick;
          w_opa_next    = 32'(w_sel_period);
          w_opb_next    = w_sel_freq;
          w_acc_next    = '0;
          w_bit_next    = '0;
          w_rr_ptr_next = (int'(w_pick) == NREQ - 1) ? '0 : w_pick + PW'(1);
          if (w_sel_period == '0 || w_sel_freq == '0) begin
            w_state_next  = S_ERR;
            w_op_err_next = 1'b1;
          end else begin
            w_state_next = S_MUL;
          end
        end
      end
      S_MUL: begin
        // opa is pre-shifted and opb consumed LSB first, so bit i adds opa << i.
        if (r_opb[0]) w_acc_next = r_acc + r_opa;
        w_opa_next = r_opa << 1;
        w_opb_next = r_opb >> 1;
        w_bit_next = r_bit + CW'(1);
        if (r_bit == CW'(W - 1)) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wrap) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        if (r_acc != r_condition) begin
          w_condition_next = r_acc;
          w_cond_upd_next  = 1'b1;
        end
        w_state_next = S_IDLE;
      end
      S_ERR: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_acc       <= '0;
      r_bit       <= '0;
      r_condition <= 32'd1;
      r_gnt       <= '0;
      r_cond_upd  <= 1'b0;
      r_op_err    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_next;
      r_opa       <= w_opa_next;
      r_opb       <= w_opb_next;
      r_acc       <= w_acc_next;
      r_bit       <= w_bit_next;
      r_condition <= w_condition_next;
      r_gnt       <= w_gnt_next;
      r_cond_upd  <= w_cond_upd_next;
      r_op_err    <= w_op_err_next;
      r_busy      <= w_busy_next;
    end
  end

  assign gnt       = r_gnt;
  assign condition = r_condition;
  assign cond_upd  = r_cond_upd;
  assign op_err    = r_op_err;
  assign busy      = r_busy;

endmodule
